dcache_flush_walker: RTL and testbench

//  Read-side companion of the dcache tag FIFO: on a flush/clean request, walks every
//  tag location in order and reads {valid,dirty,tag}. For each valid+dirty line it

---
 rtl/dcache_flush_walker.sv | 92 +++++++++
 tb/tb_dcache_flush_walker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_flush_walker.sv
// dcache_flush_walker: walks the tag FIFO, writes back dirty lines, then cleans or invalidates them
module dcache_flush_walker #(
    parameter int DP = 4,
    parameter int TAG_W = 14,
    localparam int AW = $clog2(DP),
    localparam int WD = TAG_W + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_req,
    input  logic             inv_en,
    output logic             busy,
    output logic             flush_done,
    output logic             fifo_flush,
    output logic [AW-1:0]    tag_rptr,
    input  logic             tag_rval,
    input  logic             tag_rdirty,
    input  logic [TAG_W-1:0] tag_rtag,
    output logic             wb_req,
    output logic [AW-1:0]    wb_loc,
    output logic [TAG_W-1:0] wb_tag,
    input  logic             wb_ack,
    output logic             tag_uwr,
    output logic [AW-1:0]    tag_uptr,
    output logic [WD-1:0]    tag_wdata,
    output logic [AW:0]      wb_cnt
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SCAN = 3'd1;
    localparam logic [2:0] WB   = 3'd2;
    localparam logic [2:0] UPD  = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;
    logic [2:0]    state;
    logic [AW-1:0] ptr;
    logic          inv;
    logic          last;
    assign last       = ptr == AW'(DP - 1);
    assign busy       = state != IDLE;
    assign flush_done = state == FIN;
    assign fifo_flush = state == FIN && inv;
    assign wb_req     = state == WB;
    assign tag_uwr    = state == UPD;
    assign tag_rptr   = ptr;
    assign tag_uptr   = ptr;
    assign tag_wdata  = (state == UPD && !inv) ? {1'b1, 1'b0, wb_tag} : '0;
    // walk sequencing; ptr returns to 0 on FIN so it reads 0 whenever idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            inv    <= 1'b0;
            wb_loc <= '0;
            wb_tag <= '0;
            wb_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (flush_req) begin
                    ptr    <= '0;
                    wb_cnt <= '0;
                    inv    <= inv_en;
                    state  <= SCAN;
                end
                SCAN: if (tag_rval && tag_rdirty) begin
                    wb_tag <= tag_rtag;
                    wb_loc <= ptr;
                    state  <= WB;
                end else if (tag_rval && inv) begin
                    state <= UPD;
                end else if (last) begin
                    state <= FIN;
                end else begin
                    ptr <= ptr + 1'b1;
                end
                WB: if (wb_ack) begin
                    wb_cnt <= wb_cnt + 1'b1;
                    state  <= UPD;
                end
                UPD: if (last) begin
                    state <= FIN;
                end else begin
                    ptr   <= ptr + 1'b1;
                    state <= SCAN;
                end
                FIN: begin
                    ptr   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_flush_walker.sv
// tb_dcache_flush_walker: scoreboard bench for dcache_flush_walker against a per-location walk model
module tb_dcache_flush_walker;
    localparam int DP = 4;
    localparam int TAG_W = 14;
    localparam int AW = 2;
    localparam int WD = TAG_W + 2;

    logic clk = 0;
    logic reset, flush_req, inv_en, wb_ack;
    logic busy, flush_done, fifo_flush, wb_req, tag_uwr;
    logic tag_rval, tag_rdirty;
    logic [TAG_W-1:0] tag_rtag, wb_tag;
    logic [AW-1:0] tag_rptr, wb_loc, tag_uptr;
    logic [WD-1:0] tag_wdata;
    logic [AW:0] wb_cnt;

    logic mv[DP], md[DP];
    logic [TAG_W-1:0] mt[DP];
    int dly[DP];
    int ack_mode = 0;
    int errors = 0, checks = 0, done_cnt = 0, cyc = 0;

    typedef struct { int loc; int val; } ev_t;
    typedef struct { int ff; int cnt; int cyc; } done_t;
    ev_t wbq[$], uq[$];
    done_t dq[$];

    assign tag_rval   = mv[tag_rptr];
    assign tag_rdirty = md[tag_rptr];
    assign tag_rtag   = mt[tag_rptr];

    dcache_flush_walker #(.DP(DP), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush_req(flush_req), .inv_en(inv_en),
        .busy(busy), .flush_done(flush_done), .fifo_flush(fifo_flush),
        .tag_rptr(tag_rptr), .tag_rval(tag_rval), .tag_rdirty(tag_rdirty), .tag_rtag(tag_rtag),
        .wb_req(wb_req), .wb_loc(wb_loc), .wb_tag(wb_tag), .wb_ack(wb_ack),
        .tag_uwr(tag_uwr), .tag_uptr(tag_uptr), .tag_wdata(tag_wdata), .wb_cnt(wb_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // memory-side responder: 0 = never ack, 1 = ack after dly[loc] extra cycles, 2 = ack tied high
    initial begin
        int wcnt = 0;
        wb_ack = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_mode == 0) wb_ack = 0;
            else if (ack_mode == 2) wb_ack = 1;
            else if (wb_req) begin
                wb_ack = (wcnt == dly[wb_loc]);
                wcnt = wb_ack ? 0 : wcnt + 1;
            end else begin
                wb_ack = 0;
                wcnt = 0;
            end
        end
    end

    // monitor: compares every presented output event against the front of its queue
    initial begin
        forever begin
            @(negedge clk);
            if (reset) cyc = 0;
            else begin
                if (busy) cyc++;
                if (wb_req) begin
                    if (wbq.size() == 0) chk("wb_extra", wb_req, 0);
                    else begin
                        chk("wb_loc", wb_loc, wbq[0].loc);
                        chk("wb_tag", wb_tag, wbq[0].val);
                        if (wb_ack) void'(wbq.pop_front());
                    end
                end
                if (tag_uwr) begin
                    if (uq.size() == 0) chk("upd_extra", tag_uwr, 0);
                    else begin
                        chk("tag_uptr", tag_uptr, uq[0].loc);
                        chk("tag_wdata", tag_wdata, uq[0].val);
                        void'(uq.pop_front());
                    end
                end
                if (!flush_done) chk("fifo_flush_stray", fifo_flush, 0);
                else begin
                    if (dq.size() == 0) chk("done_extra", flush_done, 0);
                    else begin
                        chk("fifo_flush", fifo_flush, dq[0].ff);
                        chk("wb_cnt", wb_cnt, dq[0].cnt);
                        chk("busy_cycles", cyc, dq[0].cyc);
                        void'(dq.pop_front());
                    end
                    cyc = 0;
                    done_cnt++;
                end
            end
        end
    end

    // model: each location independently yields writeback/update events and a cycle cost
    task automatic walk(input bit inv, input int mode, input bit extra);
        int n = 0, c = 1, d0, t = 0;
        ack_mode = mode;
        for (int i = 0; i < DP; i++) begin
            if (mv[i] && md[i]) begin
                wbq.push_back('{i, int'(mt[i])});
                uq.push_back('{i, inv ? 0 : ((1 << (WD - 1)) | int'(mt[i]))});
                n++;
                c += 3 + (mode == 2 ? 0 : dly[i]);
            end else if (mv[i] && inv) begin
                uq.push_back('{i, 0});
                c += 2;
            end else c += 1;
        end
        dq.push_back('{int'(inv), n, c});
        d0 = done_cnt;
        inv_en = inv;
        flush_req = 1;
        @(posedge clk);
        #1;
        flush_req = 0;
        inv_en = 1'($urandom_range(0, 1));
        chk("busy_start", busy, 1);
        chk("cnt_clear", wb_cnt, 0);
        if (extra) begin
            @(posedge clk);
            #1;
            flush_req = 1;
            inv_en = !inv;
            @(posedge clk);
            #1;
            flush_req = 0;
        end
        while (done_cnt == d0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("walk_timeout", done_cnt != d0, 1);
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_rptr", tag_rptr, 0);
    endtask

    task automatic fill(input int vmask, input int dmask);
        for (int i = 0; i < DP; i++) begin
            mv[i] = vmask[i];
            md[i] = dmask[i];
            mt[i] = TAG_W'($urandom);
            dly[i] = $urandom_range(0, 3);
        end
    endtask

    initial begin
        int t;
        reset = 1;
        flush_req = 0;
        inv_en = 0;
        fill(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", flush_done, 0);
        chk("rst_fifo_flush", fifo_flush, 0);
        chk("rst_wb_req", wb_req, 0);
        chk("rst_tag_uwr", tag_uwr, 0);
        chk("rst_rptr", tag_rptr, 0);
        chk("rst_wb_loc", wb_loc, 0);
        chk("rst_wb_tag", wb_tag, 0);
        chk("rst_uptr", tag_uptr, 0);
        chk("rst_wdata", tag_wdata, 0);
        chk("rst_wb_cnt", wb_cnt, 0);
        reset = 0;
        @(posedge clk);
        #1;
        // all invalid
        fill(0, 0);
        walk(0, 1, 0);
        // single dirty line with a slow ack
        fill(4'b0100, 4'b0100);
        mt[2] = 14'h1A5;
        dly[2] = 3;
        walk(0, 1, 0);
        // every line dirty, invalidate, ack tied high
        fill(4'b1111, 4'b1111);
        walk(1, 2, 0);
        // one clean valid line invalidated
        fill(4'b0010, 4'b0000);
        walk(1, 1, 0);
        // flush_req while busy is ignored; next walk clears wb_cnt
        fill(4'b1011, 4'b0011);
        walk(0, 1, 1);
        fill(0, 0);
        walk(0, 1, 0);
        // randomized walks
        for (int k = 0; k < 24; k++) begin
            fill($urandom_range(0, 15), $urandom_range(0, 15));
            walk(1'($urandom_range(0, 1)), $urandom_range(1, 2), 1'($urandom_range(0, 1)));
        end
        // reset while a writeback is pending
        fill(4'b0001, 4'b0001);
        ack_mode = 0;
        wbq.push_back('{0, int'(mt[0])});
        inv_en = 1;
        flush_req = 1;
        @(posedge clk);
        #1;
        flush_req = 0;
        t = 0;
        while (!wb_req && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("wb_req_seen", wb_req, 1);
        @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        chk("abort_wb_req", wb_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_uwr", tag_uwr, 0);
        reset = 0;
        wbq.delete();
        ack_mode = 2;
        repeat (6) @(posedge clk);
        #1;
        chk("post_abort_busy", busy, 0);
        chk("post_abort_cnt", wb_cnt, 0);
        // recovery walk after the abort
        fill($urandom_range(0, 15), $urandom_range(0, 15));
        walk(1, 1, 0);
        chk("wbq_left", wbq.size(), 0);
        chk("uq_left", uq.size(), 0);
        chk("dq_left", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
